cell_editor: RTL

Consumes the user-interface outputs (debounced click level, cursor X/Y) and turns each click into a single-cell toggle in the word-packed board memory. It requests memory ownership from the simulation engine, performs a read-modify-write of the word holding the cursor cell, then releases memory. It sits between the user interface and the board BRAM write/read port shared with the engine.

---
 rtl/cell_editor.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cell_editor.sv
// Click-to-toggle editor: on each click rising edge, borrows the board memory from the
// engine and read-modify-writes the word holding the cursor cell, flipping just that cell.
module cell_editor #(
  parameter int LOG_BOARD_SIZE = 8,
  parameter int LOG_WORD_BITS  = 4,
  parameter int MEM_LATENCY    = 2,
  localparam int WORD_W        = 2 ** LOG_WORD_BITS,
  localparam int ADDR_W        = 2 * LOG_BOARD_SIZE - LOG_WORD_BITS
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      click_in,
  input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
  input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
  input  logic                      grant_in,
  input  logic [WORD_W-1:0]         rd_data_in,
  output logic                      req_out,
  output logic                      rd_en_out,
  output logic [ADDR_W-1:0]         addr_out,
  output logic                      wr_en_out,
  output logic [WORD_W-1:0]         wr_data_out,
  output logic                      done_out
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t                   state_q;
  logic                     click_prev_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [LOG_WORD_BITS-1:0] bit_q;
  logic                     req_q;
  logic                     rd_en_q;
  logic                     wr_en_q;
  logic                     done_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [WORD_W-1:0]        wr_data_q;

  logic                     click_edge;
  logic [WORD_W-1:0]        bit_mask;

  assign click_edge = click_in & ~click_prev_q;
  assign bit_mask   = WORD_W'(1) << bit_q;

  // click_prev resets high so a button held across reset is not seen as a new click.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      click_prev_q <= 1'b1;
      cnt_q        <= '0;
      bit_q        <= '0;
      req_q        <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      done_q       <= 1'b0;
      addr_q       <= '0;
      wr_data_q    <= '0;
    end else begin
      click_prev_q <= click_in;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (click_edge) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            addr_q  <= {cursor_y_in, cursor_x_in[LOG_BOARD_SIZE-1:LOG_WORD_BITS]};
            bit_q   <= cursor_x_in[LOG_WORD_BITS-1:0];
          end
        end
        ST_REQ: begin
          if (grant_in) begin
            state_q <= ST_READ;
            rd_en_q <= 1'b1;
          end
        end
        ST_READ: begin
          state_q <= ST_WAIT;
          cnt_q   <= CNT_W'(1);
        end
        // cnt_q counts cycles since READ; the word is valid when it reaches MEM_LATENCY.
        ST_WAIT: begin
          if (cnt_q == CNT_W'(MEM_LATENCY)) begin
            state_q   <= ST_WRITE;
            wr_en_q   <= 1'b1;
            wr_data_q <= rd_data_in ^ bit_mask;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WRITE: begin
          state_q <= ST_DONE;
          req_q   <= 1'b0;
          done_q  <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          addr_q  <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          addr_q  <= '0;
        end
      endcase
    end
  end

  assign req_out     = req_q;
  assign rd_en_out   = rd_en_q;
  assign wr_en_out   = wr_en_q;
  assign done_out    = done_q;
  assign addr_out    = addr_q;
  assign wr_data_out = wr_data_q;

endmodule
